fpmul_seq: RTL

FPMUL_SEQ -- requirements
Module: fpmul_seq

---
 rtl/fpmul_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fpmul_seq.sv
// Sequential single-precision multiplier: one shift-add step per mantissa bit,
// truncating round, denormals flushed to zero.
module fpmul_seq #(
    parameter int ITER = 24
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    localparam int CW = $clog2(ITER + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t          state;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic [47:0]     acc;
    logic [CW-1:0]   cnt;

    logic            s_in;
    logic            za, zb, ia, ib, na, nb;
    logic            nan_in, inf_in, zero_in;

    // Operand classification looks at the live inputs so specials resolve at acceptance
    assign s_in = op_a[31] ^ op_b[31];
    assign za   = (op_a[30:23] == 8'h00);
    assign zb   = (op_b[30:23] == 8'h00);
    assign ia   = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
    assign ib   = (op_b[30:23] == 8'hFF) && (op_b[22:0] == 23'd0);
    assign na   = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
    assign nb   = (op_b[30:23] == 8'hFF) && (op_b[22:0] != 23'd0);

    assign nan_in  = na | nb | (ia & zb) | (ib & za);
    assign inf_in  = ia | ib;
    assign zero_in = za | zb;

    logic [23:0]        ma, mb;
    logic [47:0]        addend;
    logic               s_q;
    logic               inc;
    logic [22:0]        mant;
    logic signed [9:0]  e_norm;
    logic [31:0]        norm_res;
    logic               unused_lsbs;

    assign ma     = {1'b1, a_q[22:0]};
    assign mb     = {1'b1, b_q[22:0]};
    assign addend = {24'd0, ma} << cnt;

    assign s_q  = a_q[31] ^ b_q[31];
    assign inc  = acc[47];
    assign mant = inc ? acc[46:24] : acc[45:23];

    assign e_norm = $signed({2'b00, a_q[30:23]})
                  + $signed({2'b00, b_q[30:23]})
                  - 10'sd127
                  + $signed({9'd0, inc});

    // Product bits below the kept mantissa are dropped by truncation
    assign unused_lsbs = ^acc[22:0];

    always_comb begin
        norm_res = {s_q, e_norm[7:0], mant};
        if (e_norm >= 10'sd255) begin
            norm_res = {s_q, 8'hFF, 23'd0};
        end else if (e_norm <= 10'sd0) begin
            norm_res = {s_q, 31'd0};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= op_a;
                        b_q <= op_b;
                        acc <= '0;
                        cnt <= '0;
                        if (nan_in) begin
                            result <= QNAN;
                            state  <= DONE;
                        end else if (inf_in) begin
                            result <= {s_in, 8'hFF, 23'd0};
                            state  <= DONE;
                        end else if (zero_in) begin
                            result <= {s_in, 31'd0};
                            state  <= DONE;
                        end else begin
                            state  <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (mb[cnt]) begin
                        acc <= acc + addend;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result <= norm_res;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

endmodule
